product_deserializer: RTL and testbench
=======================================

// Module: product_deserializer
// PURPOSE
//  Downstream stage of the bit-serial 4-bit multiplier. Samples the serial product
//  stream (LSB first) framed by a START strobe and assembles PWIDTH-bit parallel words.
//  Completed words go to a one-entry holding register with a VALID/READY handshake.
//  Sticky overrun and framing-error flags and a completed-word counter are provided
//  for the sequencer.
// PARAMETERS
//  PWIDTH  8  product width in bits; bits per frame (>=2)
//  CNT_W   8  width of completed-word counter WCNT
// PORTS
//  CLK      in   1       clock; all state changes on rising edge
//  RST      in   1       asynchronous, active-high reset
//  O        in   1       serial product bit from multiplier, LSB first
//  START    in   1       1 = O carries bit 0 of a new frame this cycle
//  P        out  PWIDTH  parallel product word in holding register
//  P_VALID  out  1       holding register full
//  P_READY  in   1       consumer accepts P when P_VALID&&P_READY at edge
//  OVF      out  1       sticky: completed word dropped (holding register full)
//  FERR     out  1       sticky: START seen mid-frame
//  CLR_ERR  in   1       synchronous clear of OVF and FERR
//  WCNT     out  CNT_W   number of words loaded into holding register, wraps
// BEHAVIOUR
//  Reset (RST=1, async): state=IDLE; bit counter=0; shift reg=0; P=0;
//   P_VALID=0; OVF=0; FERR=0; WCNT=0. Outputs read reset values during reset.
//  FSM IDLE: O ignored unless START=1; START=1 -> shift[0]=O, bitcnt=1, go SHIFT.
//  FSM SHIFT: each cycle shift[bitcnt]=O, bitcnt++.
//   START=1 in SHIFT -> abort partial frame, FERR=1, shift[0]=O, bitcnt=1, stay SHIFT.
//   Cycle sampling bit PWIDTH-1 (START=0) is the completion cycle -> go IDLE.
//  Completion: word = {O, shift[PWIDTH-2:0]}. If P_VALID=0, or P_VALID&&P_READY
//   this cycle, load P=word, P_VALID=1, WCNT++ (modulo 2^CNT_W). Else drop word,
//   set OVF=1; P/P_VALID/WCNT unchanged.
//  Latency: P/P_VALID update at the same edge that samples the last bit.
//   P_VALID is high in the cycle after the last bit.
//  Handshake: P_VALID&&P_READY at edge with no load -> P_VALID=0, P holds value.
//   Simultaneous drain and load -> P=new word, P_VALID stays 1; no bubble.
//   P stable while P_VALID=1 and not accepted.
//  Back-to-back frames: START may be high in the cycle right after a completion
//   cycle (IDLE), giving a full word every PWIDTH cycles.
//  CLR_ERR=1: OVF and FERR cleared. A set event in the same cycle wins (flag =1).
//  Unused shift bits are don't-care; only complete frames reach P.
//  RST mid-frame: partial frame discarded; no word, no flag.
// TESTING
//  1 3x5: START with O=1,1,1,1,0,0,0,0 over 8 cycles, P_READY=1
//     -> P=8'h0F, P_VALID=1 for 1 cycle, WCNT=1.
//  2 Back-to-back 15x15 then 2x3 (8'hE1, 8'h06), P_READY=1
//     -> P=8'hE1 then 8'h06 exactly 8 cycles apart; WCNT=2; OVF=0.
//  3 P_READY=0, two frames 8'hE1, 8'h06 -> P holds 8'hE1, OVF=1, WCNT=1.
//     CLR_ERR pulse -> OVF=0.
//  4 P_VALID=1 (8'h0F) and 8'h24 completes while P_READY=1 -> P=8'h24,
//     P_VALID stays 1, OVF=0.
//  5 START at bit 3 of a frame -> FERR=1; next 8 bits 8'h09 -> P=8'h09.
//     Truncated frame never appears on P.
//  6 RST pulse at bit 5 of a frame, then full 8'hE1 frame
//     -> all outputs at reset values during RST; then P=8'hE1, WCNT=1.

Source files
------------

// File: rtl/product_deserializer.sv
// ---------------------------------------------------------------------------
// product_deserializer
//
// Downstream stage of the bit-serial 4-bit multiplier. It samples the serial
// product stream (LSB first), framed by a START strobe, and assembles
// PWIDTH-bit parallel words. Each completed word is offered through a
// one-entry holding register with a VALID/READY handshake. Sticky overrun
// and framing-error flags and a completed-word counter are kept for the
// sequencer.
//
// Handshake: a word in the holding register is transferred when P_VALID and
// P_READY are both high at a rising CLK edge. P is held stable while P_VALID
// is high and the word has not been taken. A new word may be loaded at the
// same edge that drains the old one, so there is no bubble.
//
// Ports
//   CLK        in   1       clock, all state changes on rising edge
//   RST        in   1       asynchronous, active-high reset
//   O          in   1       serial product bit, LSB first
//   START      in   1       O carries bit 0 of a new frame this cycle
//   P          out  PWIDTH  parallel product word in holding register
//   P_VALID    out  1       holding register full
//   P_READY    in   1       consumer accepts P
//   OVF        out  1       sticky: completed word dropped (register full)
//   FERR       out  1       sticky: START seen mid-frame
//   CLR_ERR    in   1       synchronous clear of OVF and FERR
//   WCNT       out  CNT_W   words loaded into holding register, wraps
//   state_dbg  out  1       FSM state (0 = IDLE, 1 = SHIFT)
// ---------------------------------------------------------------------------
module product_deserializer #(
  parameter int PWIDTH = 8,
  parameter int CNT_W  = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              O,
  input  logic              START,
  output logic [PWIDTH-1:0] P,
  output logic              P_VALID,
  input  logic              P_READY,
  output logic              OVF,
  output logic              FERR,
  input  logic              CLR_ERR,
  output logic [CNT_W-1:0]  WCNT,
  output logic              state_dbg
);

  localparam int BW = (PWIDTH > 2) ? $clog2(PWIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(PWIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t              state;
  logic [BW-1:0]       bitcnt;
  // Bit PWIDTH-1 is never stored: it is taken straight from O on completion.
  logic [PWIDTH-2:0]   shift_q;

  logic                complete;
  logic                load;
  logic                ovf_set;
  logic                ferr_set;
  logic [PWIDTH-1:0]   word;

  always_comb begin
    complete = 1'b0;
    ferr_set = 1'b0;
    if (state == SHIFT) begin
      ferr_set = START;
      complete = !START && (bitcnt == LAST_BIT);
    end
    word    = {O, shift_q};
    // A full register still accepts the new word if it drains this edge.
    load    = complete && (!P_VALID || P_READY);
    ovf_set = complete && P_VALID && !P_READY;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      bitcnt  <= '0;
      shift_q <= '0;
      P       <= '0;
      P_VALID <= 1'b0;
      OVF     <= 1'b0;
      FERR    <= 1'b0;
      WCNT    <= '0;
    end else begin
      // Frame assembly
      case (state)
        IDLE: begin
          if (START) begin
            shift_q[0] <= O;
            bitcnt     <= BW'(1);
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          if (START) begin
            // Restart: the partial frame is abandoned, O is bit 0 again.
            shift_q[0] <= O;
            bitcnt     <= BW'(1);
          end else if (complete) begin
            bitcnt <= '0;
            state  <= IDLE;
          end else begin
            shift_q[bitcnt] <= O;
            bitcnt          <= bitcnt + BW'(1);
          end
        end
        default: begin
          state  <= IDLE;
          bitcnt <= '0;
        end
      endcase

      // Holding register
      if (load) begin
        P       <= word;
        P_VALID <= 1'b1;
        WCNT    <= WCNT + CNT_W'(1);
      end else if (P_VALID && P_READY) begin
        P_VALID <= 1'b0;
      end

      // Sticky flags: a set event in the same cycle beats the clear.
      OVF  <= (OVF  && !CLR_ERR) || ovf_set;
      FERR <= (FERR && !CLR_ERR) || ferr_set;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_product_deserializer.sv
module tb_product_deserializer;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       O = 1'b0;
  logic       START = 1'b0;
  logic [7:0] P;
  logic       P_VALID;
  logic       P_READY = 1'b0;
  logic       OVF;
  logic       FERR;
  logic       CLR_ERR = 1'b0;
  logic [7:0] WCNT;
  logic       state_dbg;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  product_deserializer #(.PWIDTH(8), .CNT_W(8)) dut (
    .CLK(CLK), .RST(RST), .O(O), .START(START),
    .P(P), .P_VALID(P_VALID), .P_READY(P_READY),
    .OVF(OVF), .FERR(FERR), .CLR_ERR(CLR_ERR),
    .WCNT(WCNT), .state_dbg(state_dbg)
  );

  // clock / reset block
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // advance one clock; inputs change and outputs are sampled 1 ns after the edge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // drive nbits of w LSB first; P_READY = rdy_body except on bit 7 (rdy_last)
  task automatic send_bits(input logic [7:0] w, input int nbits,
                           input logic rdy_body, input logic rdy_last);
    for (int i = 0; i < nbits; i++) begin
      START   = (i == 0);
      O       = w[i];
      P_READY = (i == 7) ? rdy_last : rdy_body;
      tick();
    end
    START = 1'b0;
    O     = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_p"},     P,         32'h0);
    check({tag, "_valid"}, P_VALID,   32'h0);
    check({tag, "_ovf"},   OVF,       32'h0);
    check({tag, "_ferr"},  FERR,      32'h0);
    check({tag, "_wcnt"},  WCNT,      32'h0);
    check({tag, "_state"}, state_dbg, 32'h0);
  endtask

  logic [7:0] w0;
  int         c0;

  initial begin
    #3;
    check_reset_vals("rst");
    @(negedge CLK);
    RST = 1'b0;
    tick();

    // 1: 3x5 = 0x0F
    send_bits(8'h0F, 8, 1'b1, 1'b1);
    check("t1_p", P, 32'h0F);
    check("t1_valid", P_VALID, 32'h1);
    check("t1_wcnt", WCNT, 32'h1);
    tick();
    check("t1_drained", P_VALID, 32'h0);
    check("t1_p_hold", P, 32'h0F);

    // 2: back-to-back 0xE1 then 0x06
    w0 = WCNT;
    send_bits(8'hE1, 8, 1'b1, 1'b1);
    check("t2_p0", P, 32'hE1);
    c0 = cyc;
    send_bits(8'h06, 8, 1'b1, 1'b1);
    check("t2_p1", P, 32'h06);
    check("t2_spacing", cyc - c0, 32'd8);
    check("t2_wcnt", WCNT - w0, 32'h2);
    check("t2_ovf", OVF, 32'h0);
    tick();

    // 3: consumer stalled, second word dropped
    w0 = WCNT;
    send_bits(8'hE1, 8, 1'b0, 1'b0);
    send_bits(8'h06, 8, 1'b0, 1'b0);
    check("t3_p", P, 32'hE1);
    check("t3_valid", P_VALID, 32'h1);
    check("t3_ovf", OVF, 32'h1);
    check("t3_wcnt", WCNT - w0, 32'h1);
    CLR_ERR = 1'b1;
    tick();
    CLR_ERR = 1'b0;
    check("t3_ovf_clr", OVF, 32'h0);
    check("t3_p_stable", P, 32'hE1);
    P_READY = 1'b1;
    tick();
    check("t3_drain", P_VALID, 32'h0);

    // 4: simultaneous drain and load
    send_bits(8'h0F, 8, 1'b0, 1'b0);
    check("t4_p0", P, 32'h0F);
    send_bits(8'h24, 8, 1'b0, 1'b1);
    check("t4_p1", P, 32'h24);
    check("t4_valid", P_VALID, 32'h1);
    check("t4_ovf", OVF, 32'h0);
    P_READY = 1'b1;
    tick();
    check("t4_drain", P_VALID, 32'h0);

    // 5: START at bit 3 aborts the frame
    w0 = WCNT;
    send_bits(8'hFF, 3, 1'b1, 1'b1);
    check("t5_mid_state", state_dbg, 32'h1);
    check("t5_no_word", P_VALID, 32'h0);
    send_bits(8'h09, 8, 1'b1, 1'b1);
    check("t5_ferr", FERR, 32'h1);
    check("t5_p", P, 32'h09);
    check("t5_wcnt", WCNT - w0, 32'h1);
    CLR_ERR = 1'b1;
    tick();
    CLR_ERR = 1'b0;
    check("t5_ferr_clr", FERR, 32'h0);

    // 6: reset at bit 5 of a frame
    send_bits(8'hE1, 5, 1'b1, 1'b1);
    RST = 1'b1;
    #2;
    check_reset_vals("t6_rst");
    tick();
    RST = 1'b0;
    tick();
    send_bits(8'hE1, 8, 1'b1, 1'b1);
    check("t6_p", P, 32'hE1);
    check("t6_wcnt", WCNT, 32'h1);
    check("t6_ferr", FERR, 32'h0);
    check("t6_ovf", OVF, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
